// File: rtl/stack_pkg.sv
// Shared encodings for the stack memory stage: op codes, error codes, FSM states.
package stack_pkg;

  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BOUNDS  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  function automatic logic is_write(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return (op == OP_PUSH) || (op == OP_POP) || (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/stack_bounds_chk.sv
// Combinational check that a stack address lies inside [LO, HI] inclusive.
module stack_bounds_chk #(
  parameter int          DW = 32,
  parameter logic [DW-1:0] LO = '0,
  parameter logic [DW-1:0] HI = '1
) (
  input  logic [DW-1:0] addr,
  output logic          in_range
);
  assign in_range = (addr >= LO) && (addr <= HI);
endmodule

// File: rtl/stack_mem_access.sv
// Memory stage for stack ops: one req/ack transaction per PUSH/POP/CALL/RET.
// Optional address bounds fault enabled by STACK_BOUNDS_CHECK_EN.
module stack_mem_access
  import stack_pkg::*;
#(
  parameter int            DW          = 32,
  parameter logic [DW-1:0] STACK_LO    = 32'h0000_0F00,
  parameter logic [DW-1:0] STACK_HI    = 32'h0000_0FFF,
  parameter int            ACK_TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    stack_op,
  input  logic          start,
  input  logic [DW-1:0] mem_sp,
  input  logic [DW-1:0] push_data,
  input  logic [DW-1:0] npc,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [1:0]    err_code,
  output logic [DW-1:0] lmd,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  localparam int TW = $clog2(ACK_TIMEOUT) + 1;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic          addr_ok;
  logic          accept;

`ifdef STACK_BOUNDS_CHECK_EN
  stack_bounds_chk #(.DW(DW), .LO(STACK_LO), .HI(STACK_HI)) u_bounds (
    .addr     (mem_sp),
    .in_range (addr_ok)
  );
`else
  logic unused_bounds;
  assign unused_bounds = (STACK_LO > STACK_HI);
  assign addr_ok       = 1'b1;
`endif

  assign accept = (state == S_IDLE) && start && is_valid_op(stack_op);

  // Status outputs are pure state decodes so an async reset clears them at once.
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_RESP);
  assign err     = (state == S_ERR);
  assign mem_req = (state == S_REQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      err_code  <= ERR_NONE;
      lmd       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          mem_addr  <= mem_sp;
          mem_we    <= is_write(stack_op);
          mem_wdata <= (stack_op == OP_PUSH) ? push_data :
                       (stack_op == OP_CALL) ? npc : '0;
          timer     <= '0;
          if (addr_ok) begin
            state    <= S_REQ;
            err_code <= ERR_NONE;
          end else begin
            state    <= S_ERR;
            err_code <= ERR_BOUNDS;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!mem_we) lmd <= mem_rdata;
            state <= S_RESP;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            state    <= S_ERR;
            err_code <= ERR_TIMEOUT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
